// File: rtl/sudoku_win_checker.sv
// rtl/sudoku_win_checker.sv - scans the 81-cell board RAM and checks all 27 groups for a solved sudoku
module sudoku_win_checker #(
    parameter int CELL_W     = 4,
    parameter int ADDR_W     = 7,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              win_tag,
    output logic [4:0]        fail_group
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state;
    logic [4:0]  iss_g;
    logic [3:0]  iss_k;
    logic        chk_valid;
    logic [4:0]  chk_g;
    logic [3:0]  chk_k;
    logic [8:0]  seen;
    logic        fail_flag;

    logic [8:0]        seen_base;
    logic [8:0]        onehot;
    logic [CELL_W-1:0] digit_idx;
    logic              in_range;
    logic              sample_en;
    logic              sample_fail;
    logic              first_fail;
    logic              early_stop;
    logic              last_issue;
    logic [4:0]        nxt_g;
    logic [3:0]        nxt_k;

    // Group g, index k -> linear cell address (row*9 + col).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] g, input logic [3:0] k);
        logic [3:0] row, col, b, k_hi, k_lo, b_hi, b_lo;
        k_hi = (k >= 4'd6) ? 4'd2 : ((k >= 4'd3) ? 4'd1 : 4'd0);
        k_lo = k - k_hi * 4'd3;
        b    = 4'd0;
        b_hi = 4'd0;
        b_lo = 4'd0;
        if (g < 5'd9) begin
            row = g[3:0];
            col = k;
        end else if (g < 5'd18) begin
            row = k;
            col = 4'(g - 5'd9);
        end else begin
            b    = 4'(g - 5'd18);
            b_hi = (b >= 4'd6) ? 4'd2 : ((b >= 4'd3) ? 4'd1 : 4'd0);
            b_lo = b - b_hi * 4'd3;
            row  = b_hi * 4'd3 + k_hi;
            col  = b_lo * 4'd3 + k_lo;
        end
        return ADDR_W'(row) * ADDR_W'(9) + ADDR_W'(col);
    endfunction

    always_comb begin
        seen_base   = (chk_k == 4'd0) ? 9'd0 : seen;
        digit_idx   = rd_data - CELL_W'(1);
        in_range    = (rd_data != '0) && (rd_data <= CELL_W'(9));
        onehot      = in_range ? (9'd1 << digit_idx) : 9'd0;
        // Data arriving in DONE belongs to the read issued on the failing cycle; drop it.
        sample_en   = chk_valid && ((state == SCAN) || (state == DRAIN));
        sample_fail = sample_en && (!in_range || ((seen_base & onehot) != 9'd0));
        first_fail  = sample_fail && !fail_flag;
        early_stop  = (EARLY_EXIT != 0) && sample_fail;
        last_issue  = (iss_g == 5'd26) && (iss_k == 4'd8);
        if (iss_k == 4'd8) begin
            nxt_g = iss_g + 5'd1;
            nxt_k = 4'd0;
        end else begin
            nxt_g = iss_g;
            nxt_k = iss_k + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_tag    <= 1'b0;
            fail_group <= 5'd27;
            iss_g      <= 5'd0;
            iss_k      <= 4'd0;
            chk_valid  <= 1'b0;
            chk_g      <= 5'd0;
            chk_k      <= 4'd0;
            seen       <= 9'd0;
            fail_flag  <= 1'b0;
        end else begin
            chk_valid <= rd_en;
            chk_g     <= iss_g;
            chk_k     <= iss_k;
            done      <= 1'b0;
            if (sample_en) begin
                seen <= seen_base | onehot;
            end
            if (first_fail) begin
                fail_flag  <= 1'b1;
                fail_group <= chk_g;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        win_tag    <= 1'b0;
                        fail_group <= 5'd27;
                        fail_flag  <= 1'b0;
                        iss_g      <= 5'd0;
                        iss_k      <= 4'd0;
                        rd_en      <= 1'b1;
                        rd_addr    <= cell_addr(5'd0, 4'd0);
                    end
                end
                SCAN: begin
                    if (early_stop) begin
                        rd_en   <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                        win_tag <= 1'b0;
                    end else if (last_issue) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        iss_g   <= nxt_g;
                        iss_k   <= nxt_k;
                        rd_addr <= cell_addr(nxt_g, nxt_k);
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    done    <= 1'b1;
                    win_tag <= !(fail_flag || sample_fail);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sudoku_win_checker.md
# sudoku_win_checker

Board validator that sits directly upstream of the game controller and drives its `win_tag` input. On a `start` pulse it scans the 81-cell board RAM through a one-cycle-latency read port. It checks all 27 groups (9 rows, 9 columns, 9 boxes) for exactly the digits 1..9, then reports the result as a held `win_tag` level plus a one-cycle `done` pulse.

## Interface
- `CELL_W`, 4, width of one board cell value (0 = empty, 1..9 = digit)
- `ADDR_W`, 7, board RAM address width (cells 0..80, addr = row*9 + col)
- `EARLY_EXIT`, 1, 1 = stop scan at first failing group; 0 = always scan all 243 reads
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a full board check; sampled only in IDLE
- `rd_en`  out  1  board RAM read strobe
- `rd_addr`  out  ADDR_W  board RAM read address
- `rd_data`  in  CELL_W  cell value; valid the cycle after `rd_en`
- `busy`  out  1  high while not IDLE
- `done`  out  1  one-cycle pulse, check finished
- `win_tag`  out  1  1 = last completed check found a valid solved board; held
- `fail_group`  out  5  first failing group index 0..26 (0-8 rows, 9-17 cols, 18-26 boxes); 27 = none

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `start`=1 -> SCAN; clear `win_tag` to 0 and set `fail_group` to 27 on the same edge; group g=0, index k=0.
- SCAN: each cycle assert `rd_en` with the address for (g,k), then advance k; at k=8 wrap to k=0, g+1. After issuing (26,8) -> DRAIN.
- Address map:
  - row group g<9: row=g, col=k
  - col group 9<=g<18: row=k, col=g-9
  - box group b=g-18: row=3*(b/3)+k/3, col=3*(b%3)+k%3
- Checker pipeline, operating on returned data with the group/index tag delayed one cycle:
  - 9-bit seen mask, cleared when tag k=0.
  - A sample fails if the value is 0, the value is >9, or its mask bit is already set.
  - On the first failure, latch `fail_group`=tag g and set a sticky fail flag.
- EARLY_EXIT=1: on the failing sample, stop issuing reads (`rd_en`=0) and go to DONE.
- DRAIN: one cycle to sample the last read -> DONE.
- DONE: `done`=1 for one cycle; `win_tag` <= !fail; -> IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `rd_data` is ignored whenever no read was issued the previous cycle.

## Timing
- Reset values:
  - state IDLE
  - `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0
  - `win_tag`=0, `fail_group`=27
  - mask and fail flag cleared
- Cycle numbering: start sampled high at the edge ending cycle 0.
  - Read i (0..242) issued in cycle 1+i.
  - Its data is sampled at the edge ending cycle 2+i.
- Passing board: `done` and updated `win_tag` (=1) are visible in cycle 245. `busy` is high in cycles 1..245 and low in cycle 246.
- Failure in read i with EARLY_EXIT=1:
  - Read i+1 is still issued in cycle 2+i; its data is discarded.
  - `rd_en`=0 from cycle 3+i.
  - `done` is in cycle 3+i with `win_tag`=0.
- EARLY_EXIT=0: `done` is always in cycle 245.
- `win_tag` and `fail_group` hold their values until the next accepted `start` or `rst`.
- `rst` mid-scan: the next cycle shows all reset values, with no `done` pulse. A `start` in the same cycle as `rst` is ignored.
- Back-to-back: a `start` held high through DONE is accepted in the following IDLE cycle, i.e. one cycle after `done`.

## Test plan
- Valid solved board, single `start` -> 243 reads with addresses matching the map, `done` in cycle 245, `win_tag`=1, `fail_group`=27.
- Solved board with cell 40 set to 0, EARLY_EXIT=1:
  - cell 40 is read 40, failing in group 4
  - -> `fail_group`=4, `done` in cycle 43, `win_tag`=0, `rd_en` low from cycle 43
- Solved board with cells 0 and 1 swapped -> all row groups pass; `fail_group`=9; `win_tag`=0; `done` before cycle 245 (EARLY_EXIT=1) or exactly 245 (EARLY_EXIT=0).
- Cell 80 = 10 (out of range), EARLY_EXIT=0 -> `fail_group`=8, `done` in cycle 245, `win_tag`=0.
- Pulse `start` again in cycles 5 and 100 -> both ignored, exactly one `done`.
- Assert `rst` in cycle 120 -> cycle 121 has `busy`=0, `rd_en`=0, `win_tag`=0, `fail_group`=27, and no `done`. A fresh `start` then completes normally.
